// File: rtl/mil_pkg.sv
// Shared MIL-STD-1553 constants and word-framing helpers, used by both the
// transmitter and the receiver.
package mil_pkg;

  localparam int HALF_BIT_CLKS_DFLT = 25;
  localparam int WORD_HALVES        = 40;

  localparam logic [5:0] SYNC_CMD = 6'b111000;
  localparam logic [5:0] SYNC_DAT = 6'b000111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  function automatic logic odd_parity(input logic [15:0] word);
    return ~^word;
  endfunction

  // Half-bit pattern with half 0 in the MSB, so the frame shifts out to the left.
  function automatic logic [WORD_HALVES-1:0] build_frame(input logic [15:0] word,
                                                         input logic        is_cmd);
    logic [WORD_HALVES-1:0] frame;
    logic                   par;
    frame         = '0;
    frame[39:34]  = is_cmd ? SYNC_CMD : SYNC_DAT;
    for (int i = 0; i < 16; i++) begin
      frame[33 - 2*i] = word[15 - i];
      frame[32 - 2*i] = ~word[15 - i];
    end
    par      = odd_parity(word);
    frame[1] = par;
    frame[0] = ~par;
    return frame;
  endfunction

endpackage

// File: rtl/mil_halfbit_timer.sv
// Half-bit timer: a one-clock tick every HALF_BIT_CLKS enabled clocks.
// load restarts the count so a freshly accepted word gets a full first half.
module mil_halfbit_timer
  import mil_pkg::*;
#(
  parameter int HALF_BIT_CLKS = HALF_BIT_CLKS_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  output logic tick
);

  localparam int              CW   = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam logic [CW-1:0]   LAST = CW'(HALF_BIT_CLKS - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || load || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mil_manchester_tx.sv
// MIL-STD-1553 Manchester II word transmitter: sync + 16 data bits + odd
// parity, with a valid/ready handshake that allows gapless back-to-back words.
module mil_manchester_tx
  import mil_pkg::*;
#(
  parameter int HALF_BIT_CLKS = HALF_BIT_CLKS_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        sync_cmd,
  input  logic        valid,
  output logic        ready,
  output logic        TXP,
  output logic        TXN,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST_HALF = 6'(WORD_HALVES - 1);

  tx_state_t              r_state, w_state_next;
  logic [WORD_HALVES-1:0] r_pattern, w_pattern_next;
  logic [5:0]             r_half, w_half_next;
  logic                   r_txp, r_txn, r_busy;
  logic                   w_en, w_tick, w_last, w_ready, w_xfer, w_send_next;

  assign w_en = (r_state == ST_SEND);

  mil_halfbit_timer #(
    .HALF_BIT_CLKS(HALF_BIT_CLKS)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .load(w_xfer),
    .tick(w_tick)
  );

  always_comb begin
    w_state_next   = r_state;
    w_pattern_next = r_pattern;
    w_half_next    = r_half;
    w_last         = w_en && w_tick && (r_half == LAST_HALF);
    w_ready        = (r_state == ST_IDLE) || w_last;
    w_xfer         = valid && w_ready;

    case (r_state)
      ST_IDLE: if (w_xfer) w_state_next = ST_SEND;
      ST_SEND: if (w_last) w_state_next = w_xfer ? ST_SEND : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase

    // A transfer on the final clock overrides the end-of-word cleanup.
    if (w_xfer) begin
      w_pattern_next = build_frame(din, sync_cmd);
      w_half_next    = '0;
    end else if (w_last) begin
      w_pattern_next = '0;
      w_half_next    = '0;
    end else if (w_tick) begin
      w_pattern_next = {r_pattern[WORD_HALVES-2:0], 1'b0};
      w_half_next    = r_half + 6'd1;
    end

    w_send_next = (w_state_next == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_half    <= '0;
      r_txp     <= 1'b0;
      r_txn     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pattern <= w_pattern_next;
      r_half    <= w_half_next;
      r_txp     <= w_send_next &&  w_pattern_next[WORD_HALVES-1];
      r_txn     <= w_send_next && !w_pattern_next[WORD_HALVES-1];
      r_busy    <= w_send_next;
    end
  end

  assign ready = w_ready;
  assign done  = w_last;
  assign TXP   = r_txp;
  assign TXN   = r_txn;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mil_manchester_tx.sv
// Scoreboarded bench for mil_manchester_tx: accepted words are queued by the
// driver and a free-running monitor checks every clock of each word on the line.
module tb_mil_manchester_tx;

  localparam int HB   = 25;
  localparam int WCLK = 40 * HB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'h0000;
  logic        sync_cmd = 1'b0;
  logic        valid = 1'b0;
  logic        ready, TXP, TXN, busy, done;

  mil_manchester_tx #(.HALF_BIT_CLKS(HB)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .sync_cmd(sync_cmd),
    .valid   (valid),
    .ready   (ready),
    .TXP     (TXP),
    .TXN     (TXN),
    .busy    (busy),
    .done    (done)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        s;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ncyc = 0;
  int   nwords = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  // Line level of half h of a word, straight from the framing rules.
  function automatic logic ref_half(input logic [15:0] d, input logic s, input int h);
    logic b;
    if (h < 6) return s ? (h < 3) : (h >= 3);
    if (h < 38) b = d[15 - (h - 6) / 2];
    else        b = (($countones(d) % 2) == 0);
    return (h % 2 == 0) ? b : ~b;
  endfunction

  // ---------------- monitor ----------------
  bit   in_word = 0;
  int   k = 0;
  exp_t cur;
  int   e_txp, e_diff, e_rdy, e_done;
  int   idle_len = 0;
  int   idle_bad = 0;
  logic exp_p, lst;

  task automatic close_idle();
    if (idle_len > 0) check(idle_bad == 0, "idle_quiet_cycles_bad", idle_bad, 0);
    idle_len = 0;
    idle_bad = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_word = 0;
        continue;
      end
      if (!in_word && busy) begin
        close_idle();
        check(exp_q.size() > 0, "word_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else                  cur = '{d: 16'h0, s: 1'b0, acc: ncyc - 1};
        check(ncyc == cur.acc + 1, "start_latency", ncyc - cur.acc, 1);
        in_word = 1;
        k = 0;
        e_txp = 0; e_diff = 0; e_rdy = 0; e_done = 0;
      end
      if (in_word) begin
        exp_p = ref_half(cur.d, cur.s, k / HB);
        if (TXP !== exp_p) e_txp++;
        if (busy !== 1'b1 || TXN !== ~TXP) e_diff++;
        lst = (k == WCLK - 1);
        if (ready !== lst) e_rdy++;
        if (done !== lst) e_done++;
        if (lst) begin
          $display("word %0d din=%h sync_cmd=%0d accepted_cycle=%0d", nwords, cur.d, cur.s, cur.acc);
          check(e_txp == 0, "txp_half_pattern_errs", e_txp, 0);
          check(e_diff == 0, "differential_busy_errs", e_diff, 0);
          check(e_rdy == 0, "ready_timing_errs", e_rdy, 0);
          check(e_done == 0, "done_timing_errs", e_done, 0);
          in_word = 0;
          nwords++;
        end
        k++;
      end else begin
        idle_len++;
        if (TXP !== 1'b0 || TXN !== 1'b0 || ready !== 1'b1 || done !== 1'b0) idle_bad++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_alt(input logic [15:0] d, input logic s,
                          input int alt_at, input logic [15:0] alt_d);
    bit acc_ok = 0;
    din = d; sync_cmd = s; valid = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if (t == alt_at) din = alt_d;
      @(negedge clk);
      if (ready === 1'b1 && !rst) begin
        exp_q.push_back('{d: din, s: sync_cmd, acc: ncyc});
        acc_ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check(acc_ok, "accept_within_bound", acc_ok, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic s);
    send_alt(d, s, -1, 16'h0);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (!busy && !in_word && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(ok, "drain_within_bound", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({TXP, TXN, busy, done, ready} == 5'b00001, "reset_outputs",
          int'({TXP, TXN, busy, done, ready}), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;

    // single command word
    send(16'hDEF0, 1'b1);
    wait_idle();

    // back-to-back command + data word, valid held
    send(16'hDEF0, 1'b1);
    send(16'h2233, 1'b0);
    wait_idle();

    // parity extremes
    send(16'h0001, 1'b0); wait_idle();
    send(16'hFFFF, 1'b1); wait_idle();
    send(16'h0000, 1'b0); wait_idle();

    // hold-off: valid at clock ~300 of a word, din changes at ~500
    send(16'h1234, 1'b1);
    repeat (299) @(posedge clk); #1;
    send_alt(16'hABCD, 1'b0, 200, 16'h5A5A);
    wait_idle();

    // mid-word reset then a clean new word
    send(16'hC3C3, 1'b1);
    repeat (449) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check({TXP, TXN, busy, done, ready} == 5'b00001, "post_reset_outputs",
          int'({TXP, TXN, busy, done, ready}), 1);
    @(posedge clk); #1;
    send(16'h0F0F, 1'b0);
    wait_idle();

    // random stream with random gaps (zero gap = back-to-back)
    for (int n = 0; n < 50; n++) begin
      int gap;
      send(16'($urandom), 1'($urandom_range(0, 1)));
      din = 16'($urandom);
      sync_cmd = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    repeat (10) @(posedge clk);
    @(negedge clk);
    close_idle();
    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
